// File: rtl/idex_pipe_hazard_pkg.sv
// Shared definitions for the ID/EX pipeline register with load-use hazard control.
// Holds the width defaults, the bubble-sequencer state type and the ALU opcode map.
package idex_pipe_hazard_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } pipeStateT;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_LLB  = 4'h8;
  localparam logic [3:0] ALU_LHB  = 4'h9;
  localparam logic [3:0] ALU_PASS = 4'hF;

endpackage

// File: rtl/idex_pipe_hazard_hazard_detect.sv
// Combinational load-use comparator between the EX-stage load and the ID-stage reader.
// Define IDEX_LB_HAZARD_EN to also treat LLB/LHB destination reads as a hazard.
module hazard_detect
  import idex_pipe_hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             enable,
  input  logic             exValid,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exDstReg,
  input  logic             idValid,
  input  logic             idIsLB,
  input  logic [REG_W-1:0] idSrcReg1,
  input  logic [REG_W-1:0] idSrcReg2,
  input  logic [REG_W-1:0] idDstReg,
  output logic             lu
);

  logic srcMatch;
  logic lbMatch;

  assign srcMatch = (exDstReg == idSrcReg1) || (exDstReg == idSrcReg2);

`ifdef IDEX_LB_HAZARD_EN
  // LLB/LHB merge a byte into their destination, so they read it too.
  assign lbMatch = idIsLB && (exDstReg == idDstReg);
`else
  logic unusedLbInputs;
  assign unusedLbInputs = ^{idIsLB, idDstReg};
  assign lbMatch        = 1'b0;
`endif

  // R0 is hardwired to zero, so a load into it never creates a dependency.
  assign lu = enable && exValid && exMemRead && (exDstReg != '0) &&
              idValid && (srcMatch || lbMatch);

endmodule

// File: rtl/idex_pipe_hazard.sv
// ID/EX pipeline register with one-cycle load-use bubble insertion and a bubble counter.
// Optional macro IDEX_LB_HAZARD_EN widens the hazard check to LLB/LHB destinations.
module idex_pipe_hazard
  import idex_pipe_hazard_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_is_LB,
  input  logic [REG_W-1:0]  id_SrcReg1,
  input  logic [REG_W-1:0]  id_SrcReg2,
  input  logic [REG_W-1:0]  id_DstReg,
  input  logic [3:0]        id_ALUop,
  input  logic [DATA_W-1:0] id_RegData1,
  input  logic [DATA_W-1:0] id_RegData2,
  input  logic [DATA_W-1:0] id_Imm,
  input  logic [DATA_W-1:0] id_PCplus2,
  input  logic              flush,
  input  logic              stall_ext,
  output logic              ex_valid,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_is_LB,
  output logic [REG_W-1:0]  ex_SrcReg1,
  output logic [REG_W-1:0]  ex_SrcReg2,
  output logic [REG_W-1:0]  ex_DstReg,
  output logic [3:0]        ex_ALUop,
  output logic [DATA_W-1:0] ex_RegData1,
  output logic [DATA_W-1:0] ex_RegData2,
  output logic [DATA_W-1:0] ex_Imm,
  output logic [DATA_W-1:0] ex_PCplus2,
  output logic              stall_IFID,
  output logic [15:0]       stall_cnt
);

  pipeStateT state;
  logic      lu;
  logic      squash;

  hazard_detect #(.REG_W(REG_W)) uHazard (
    .enable    (state == RUN),
    .exValid   (ex_valid),
    .exMemRead (ex_MemRead),
    .exDstReg  (ex_DstReg),
    .idValid   (id_valid),
    .idIsLB    (id_is_LB),
    .idSrcReg1 (id_SrcReg1),
    .idSrcReg2 (id_SrcReg2),
    .idDstReg  (id_DstReg),
    .lu        (lu)
  );

  assign stall_IFID = stall_ext | lu;
  assign squash     = flush | lu;

  // NOTE: every register here uses <= so all fields sample the same pre-edge values;
  // the async reset also clears the whole bank so EX never sees stale control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      stall_cnt   <= '0;
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_is_LB    <= 1'b0;
      ex_SrcReg1  <= '0;
      ex_SrcReg2  <= '0;
      ex_DstReg   <= '0;
      ex_ALUop    <= '0;
      ex_RegData1 <= '0;
      ex_RegData2 <= '0;
      ex_Imm      <= '0;
      ex_PCplus2  <= '0;
    end else if (!stall_ext) begin
      // Data fields are don't-care in a bubble, so they load unconditionally.
      ex_SrcReg1  <= id_SrcReg1;
      ex_SrcReg2  <= id_SrcReg2;
      ex_DstReg   <= id_DstReg;
      ex_ALUop    <= id_ALUop;
      ex_RegData1 <= id_RegData1;
      ex_RegData2 <= id_RegData2;
      ex_Imm      <= id_Imm;
      ex_PCplus2  <= id_PCplus2;

      ex_valid    <= id_valid & ~squash;
      ex_RegWrite <= id_RegWrite & id_valid & ~squash;
      ex_MemRead  <= id_MemRead & id_valid & ~squash;
      ex_MemWrite <= id_MemWrite & id_valid & ~squash;
      ex_is_LB    <= id_is_LB & id_valid & ~squash;

      if (flush) begin
        state <= RUN;
      end else if (lu) begin
        state <= BUBBLE;
        if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      end else begin
        state <= RUN;
      end
    end
  end

endmodule
